// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/accumulate unit that owns the MIPS HI/LO pair.
// It executes mult/multu/madd/msub with a radix-2 shift-add loop, plus mthi/mtlo.
`default_nettype none

module hilo_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] HiOUT,
  output logic [DATA_WIDTH-1:0] LoOUT
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t         state;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] prod;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic [1:0]     op_r;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           done;
  logic           mt_pend;

  logic           signed_op;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [2*W-1:0] p_fin;
  logic [2*W-1:0] acc;

  // Magnitude of the most negative value wraps to itself, which is exact as unsigned.
  assign signed_op = (Op != 3'b001);
  assign abs_a     = (signed_op && A[W-1]) ? (~A + 1'b1) : A;
  assign abs_b     = (signed_op && B[W-1]) ? (~B + 1'b1) : B;
  assign p_fin     = neg ? (~prod + 1'b1) : prod;
  assign acc       = {hi, lo};

  assign Busy  = (state != S_IDLE);
  assign Done  = done;
  assign HiOUT = hi;
  assign LoOUT = lo;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      op_r    <= 2'b00;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      mt_pend <= 1'b0;
    end else begin
      // mthi/mtlo report completion one cycle after the register write.
      done    <= mt_pend;
      mt_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (!Op[2]) begin
              mcand  <= {{W{1'b0}}, abs_a};
              mplier <= abs_b;
              neg    <= signed_op & (A[W-1] ^ B[W-1]);
              op_r   <= Op[1:0];
              prod   <= '0;
              cnt    <= '0;
              state  <= S_CALC;
            end else if (!Op[1]) begin
              if (Op[0]) lo <= A;
              else       hi <= A;
              mt_pend <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= S_FINISH;
        end
        S_FINISH: begin
          case (op_r)
            2'b10:   {hi, lo} <= acc + p_fin;
            2'b11:   {hi, lo} <= acc - p_fin;
            default: {hi, lo} <= p_fin;
          endcase
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: stimulus pushes expected {HI,LO}, a monitor checks on Done.
`default_nettype none

module tb_hilo_mdu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HiOUT, LoOUT;

  hilo_mdu #(.DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HiOUT(HiOUT), .LoOUT(LoOUT)
  );

  always #5 Clk = ~Clk;

  logic [63:0] q_exp[$];
  logic [63:0] acc_m;
  int          tests = 0;
  int          fails = 0;
  int          done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      done_seen++;
      if (q_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got HI=%h LO=%h expected no Done", HiOUT, LoOUT);
      end else begin
        check("result", {HiOUT, LoOUT}, q_exp.pop_front());
        check("done_with_busy", {63'd0, Busy}, 64'd0);
      end
    end
  end

  // Model uses plain 64-bit arithmetic on sign/zero-extended operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: acc_m = sp;
      3'd1: acc_m = up;
      3'd2: acc_m = acc_m + sp;
      3'd3: acc_m = acc_m - sp;
      3'd4: acc_m[63:32] = a;
      3'd5: acc_m[31:0] = a;
      default: ;
    endcase
    if (op <= 3'd5) q_exp.push_back(acc_m);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(input int lat, input logic busy_exp, input string name);
    int n = 0;
    bit got = 0;
    bit bad = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      n++;
      if (Done === 1'b1) got = 1;
      else if (Busy !== busy_exp) bad = 1;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy"}, {63'd0, bad}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ds;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    Reset = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    acc_m = '0;
    repeat (3) @(negedge Clk);
    check("reset_state", {30'd0, Busy, Done, HiOUT, LoOUT}, 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Reserved ops: nothing changes, no Done.
    ds = done_seen;
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    issue(3'd7, 32'h1234_5678, 32'h2);
    repeat (3) @(negedge Clk);
    check("reserved_regs", {HiOUT, LoOUT}, 64'd0);
    check("reserved_nodone", 64'(done_seen - ds), 64'd0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(34, 1'b1, "mult_neg");
    check("mult_neg_val", {HiOUT, LoOUT}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(34, 1'b1, "multu_max");
    check("multu_max_val", {HiOUT, LoOUT}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(34, 1'b1, "mult_min");
    check("mult_min_val", {HiOUT, LoOUT}, 64'h4000_0000_0000_0000);

    issue(3'd4, 32'd0, 32'd0);
    check("mthi_immediate", {32'd0, HiOUT}, 64'd0);
    wait_done(2, 1'b0, "mthi");
    issue(3'd5, 32'd10, 32'd0);
    check("mtlo_immediate", {32'd0, LoOUT}, 64'd10);
    wait_done(2, 1'b0, "mtlo");
    issue(3'd2, 32'd2, 32'd3);
    wait_done(34, 1'b1, "madd");
    check("madd_val", {HiOUT, LoOUT}, 64'd16);
    issue(3'd3, 32'd4, 32'd5);
    wait_done(34, 1'b1, "msub");
    check("msub_val", {HiOUT, LoOUT}, 64'hFFFF_FFFF_FFFF_FFFC);

    // Start during CALC must be ignored.
    issue(3'd0, 32'd5, 32'd6);
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 3'd5; A = 32'h1234; B = 32'd77;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = 32'hFFFF_0000; B = 32'h0000_FFFF;
    wait_done(29, 1'b1, "mult_ignore");
    check("mult_ignore_val", {HiOUT, LoOUT}, 64'd30);
    // Back-to-back accept in the Done cycle.
    issue(3'd1, 32'd100, 32'd3);
    wait_done(34, 1'b1, "b2b");
    check("b2b_val", {HiOUT, LoOUT}, 64'd300);

    // Asynchronous reset in the middle of CALC.
    issue(3'd1, 32'd100, 32'd100);
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("midcalc_reset", {31'd0, Busy, HiOUT, LoOUT}, 64'd0);
    q_exp.delete();
    acc_m = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    issue(3'd1, 32'd100, 32'd100);
    wait_done(34, 1'b1, "after_reset");
    check("after_reset_val", {HiOUT, LoOUT}, 64'd10000);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rnd_operand();
      rb  = rnd_operand();
      issue(rop, ra, rb);
      if (rop <= 3'd3) wait_done(34, 1'b1, "rnd_mul");
      else if (rop <= 3'd5) wait_done(2, 1'b0, "rnd_mt");
      else begin
        repeat (2) @(negedge Clk);
        check("rnd_reserved", {HiOUT, LoOUT}, acc_m);
      end
    end

    repeat (3) @(negedge Clk);
    check("queue_drained", 64'(q_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/accumulate unit that owns the MIPS HI/LO register pair and drives the HI/LO values consumed by the EX-stage ALU for mfhi/mflo. It executes mult, multu, madd, msub, mthi and mtlo using a radix-2 shift-add datapath. It raises Busy so the pipeline stalls until the 64-bit result is committed. The ALU no longer holds HI/LO state; it reads HiOUT/LoOUT from this block.

## Interface
- DATA_WIDTH, 32, operand width; HI/LO are each DATA_WIDTH, product is 2*DATA_WIDTH.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  request; sampled only while Busy=0.
- Op  in  3  000 mult, 001 multu, 010 madd, 011 msub, 100 mthi, 101 mtlo, 110/111 reserved.
- A  in  DATA_WIDTH  rs operand (also the mthi/mtlo source).
- B  in  DATA_WIDTH  rt operand.
- Busy  out  1  high while a multiply-class op is in flight.
- Done  out  1  registered one-cycle pulse when HI/LO have been updated.
- HiOUT  out  DATA_WIDTH  current HI register.
- LoOUT  out  DATA_WIDTH  current LO register.

## Operation
- States: IDLE, CALC, FINISH. Busy = (state != IDLE).
- IDLE, Start=1, Op in {000,001,010,011}:
  - Latch |A| and |B|. Magnitudes are used for signed ops (000, 010, 011); raw values for multu.
  - Latch neg = A[31]^B[31] for signed ops, 0 for multu.
  - Latch Op. Clear the 64-bit partial product and the 5-bit counter. Go to CALC.
- CALC: each cycle, if multiplier bit[0]=1, add multiplicand to partial product. Shift multiplicand left 1 and multiplier right 1, then counter++. After the cycle processing bit 31 (counter==31), go to FINISH.
- FINISH: P = neg ? -prod : prod (64-bit two's complement).
  - mult/multu: {HI,LO} <= P.
  - madd: {HI,LO} <= {HI,LO} + P.
  - msub: {HI,LO} <= {HI,LO} - P.
  - All arithmetic is mod 2^64, with no overflow flag.
  - Done <= 1; go to IDLE.
- IDLE, Start=1, Op=100: HI <= A at that edge; Done <= 1 next cycle; Busy stays 0.
- IDLE, Start=1, Op=101: LO <= A at that edge; Done <= 1 next cycle; Busy stays 0.
- Op 110/111: no state change, no Done.
- Start while Busy=1 is ignored. Operand changes during CALC have no effect.
- |A| for A=0x80000000 is 0x80000000, treated as unsigned 32-bit; the result is exact.
- HI/LO change only at FINISH or on an mthi/mtlo accept. They hold otherwise, including across reserved ops.

## Timing
- Reset (asynchronous assert, any state, including mid-CALC):
  - state=IDLE, Busy=0, Done=0, HiOUT=0, LoOUT=0.
  - Counter and datapath registers are cleared.
  - The in-flight operation is discarded.
- Multiply-class accept at edge E0 (Start=1, Busy=0):
  - Busy=1 from after E0 until after E33 (33 cycles).
  - CALC occupies edges E1..E32; FINISH commits at E33.
  - HiOUT/LoOUT show the new value after E33, and Done=1 for exactly the cycle after E33.
  - Total latency: 34 edges from accept to Done observed.
- mthi/mtlo accept at E0: register updated after E0; Done=1 during the cycle after E1.
- Start asserted in the cycle Done=1: state is IDLE, so Start is accepted (back-to-back ops, no bubble).
- Done is never high together with Busy.
- ALU reads of HiOUT/LoOUT are combinational from the registers. Upstream stall logic must hold mfhi/mflo while Busy=1.

## Test plan
- Reset: drive Reset=0 mid-run, then release -> Busy=0, Done=0, HiOUT=0, LoOUT=0. Repeated Start with Op=110 -> no change, no Done.
- mult A=0xFFFFFFFD (-3), B=7 -> Busy high 33 cycles; after E33, HiOUT=0xFFFFFFFF, LoOUT=0xFFFFFFEB; Done one cycle.
- multu A=B=0xFFFFFFFF -> HiOUT=0xFFFFFFFE, LoOUT=0x00000001. Then mult A=B=0x80000000 -> HiOUT=0x40000000, LoOUT=0x00000000.
- mthi 0, mtlo 10, then madd A=2, B=3:
  - After madd: HiOUT=0, LoOUT=16.
  - Then msub A=4, B=5 -> HiOUT=0xFFFFFFFF, LoOUT=0xFFFFFFFC.
  - mthi/mtlo show Busy=0 throughout.
- During CALC of mult 5*6, pulse Start with Op=101, A=0x1234 and change A/B -> ignored; final HiOUT=0, LoOUT=30. Start in the Done cycle -> accepted immediately.
- Assert Reset at the 10th CALC cycle of multu 100*100 -> Busy=0, HI/LO=0 immediately. After release, multu 100*100 -> LoOUT=10000 after 34 edges.
